// File: rtl/bht_gshare_predictor_if.sv
// Fetch/execute-side signal bundle for the gshare branch direction predictor.
// master = pipeline driving lookups and resolutions, slave = the predictor.
interface bht_gshare_predictor_if #(
    parameter int IDX_W  = 5,
    parameter int HIST_W = 4
);
    localparam int HW = (HIST_W > 0) ? HIST_W : 1;

    logic             rd_valid;
    logic [IDX_W-1:0] rd_idx;
    logic             pred_taken;
    logic [HW-1:0]    pred_hist;
    logic             upd_en;
    logic [IDX_W-1:0] upd_idx;
    logic [HW-1:0]    upd_hist;
    logic             upd_taken;
    logic             upd_mispredict;

    modport master (
        output rd_valid, rd_idx, upd_en, upd_idx, upd_hist, upd_taken, upd_mispredict,
        input  pred_taken, pred_hist
    );

    modport slave (
        input  rd_valid, rd_idx, upd_en, upd_idx, upd_hist, upd_taken, upd_mispredict,
        output pred_taken, pred_hist
    );
endinterface

// File: rtl/bht_gshare_predictor.sv
// Flop-based table of saturating counters with optional gshare history folding.
// Combinational lookup in fetch, counter training and GHR repair from execute.
module bht_gshare_predictor #(
    parameter int IDX_W    = 5,
    parameter int CNT_W    = 2,
    parameter int HIST_W   = 4,
    parameter int INIT_CNT = 1
) (
    input  logic                   clk,
    input  logic                   arst_n,
    bht_gshare_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int HW      = (HIST_W > 0) ? HIST_W : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(INIT_CNT);

    logic [ENTRIES-1:0][CNT_W-1:0] cnt;
    logic [HW-1:0]                 ghr;
    logic [IDX_W-1:0]              ghr_ext, uhist_ext, eidx, uidx;
    logic [CNT_W-1:0]              ucnt, ucnt_nxt, rcnt;
    logic                          hit;

    generate
        if (HIST_W == 0) begin : g_bimodal
            assign ghr       = '0;
            assign ghr_ext   = '0;
            assign uhist_ext = '0;
        end else begin : g_gshare
            logic [HW-1:0] spec_nxt, rep_nxt;
            if (HIST_W == 1) begin : g_h1
                assign spec_nxt = bp.pred_taken;
                assign rep_nxt  = bp.upd_taken;
            end else begin : g_hn
                assign spec_nxt = {ghr[HW-2:0], bp.pred_taken};
                assign rep_nxt  = {bp.upd_hist[HW-2:0], bp.upd_taken};
            end
            assign ghr_ext   = IDX_W'(ghr);
            assign uhist_ext = IDX_W'(bp.upd_hist);

            // Misprediction repair overrides the speculative shift of the same cycle.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n)                              ghr <= '0;
                else if (bp.upd_en && bp.upd_mispredict)  ghr <= rep_nxt;
                else if (bp.rd_valid)                     ghr <= spec_nxt;
            end
        end
    endgenerate

    assign eidx = bp.rd_idx ^ ghr_ext;
    assign uidx = bp.upd_idx ^ uhist_ext;
    assign ucnt = cnt[uidx];

    always_comb begin
        ucnt_nxt = ucnt;
        if (bp.upd_taken) begin
            if (ucnt != CNT_MAX) ucnt_nxt = ucnt + 1'b1;
        end else begin
            if (ucnt != '0)      ucnt_nxt = ucnt - 1'b1;
        end
    end

    // Same-cycle update to the entry being read is forwarded to the prediction.
    assign hit           = bp.upd_en && (uidx == eidx);
    assign rcnt          = hit ? ucnt_nxt : cnt[eidx];
    assign bp.pred_taken = rcnt[CNT_W-1];
    assign bp.pred_hist  = ghr;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int e = 0; e < ENTRIES; e++) cnt[e] <= CNT_RST;
        end else if (bp.upd_en) begin
            cnt[uidx] <= ucnt_nxt;
        end
    end
endmodule

// File: doc/bht_gshare_predictor.md
Name: bht_gshare_predictor

Overview:
Parametrised branch direction predictor that replaces the fixed 32-entry, 2-bit SRAM-backed branch history table. It is a flop-based table of saturating counters indexed by the PC index. An optional global history register (GHR) is XOR-folded into the index (gshare), and the GHR is speculatively updated with a repair path. It sits beside the fetch stage: reads are combinational in fetch, and updates arrive from execute when the branch resolves.

Parameters:
IDX_W, 5, table index width; the table has 2^IDX_W entries.
CNT_W, 2, counter width, 2..4.
HIST_W, 4, GHR length, 0..IDX_W; 0 = pure bimodal, and the GHR logic is removed.
INIT_CNT, 1, counter reset value (1 = weakly not-taken for CNT_W=2).

Ports:
clk  input  1  clock, rising edge.
arst_n  input  1  asynchronous active-low reset.
rd_valid  input  1  fetch holds a branch this cycle; shifts the GHR speculatively.
rd_idx  input  IDX_W  PC index bits of the fetched branch.
pred_taken  output  1  predicted direction for rd_idx.
pred_hist  output  max(HIST_W,1)  GHR snapshot used for this prediction; carried down the pipe.
upd_en  input  1  a branch resolves this cycle.
upd_idx  input  IDX_W  PC index of the resolving branch.
upd_hist  input  max(HIST_W,1)  pred_hist captured at that branch's prediction.
upd_taken  input  1  actual outcome.
upd_mispredict  input  1  the resolved direction differs from the prediction; qualified by upd_en.

Behaviour:
- Reset:
  - All counters = INIT_CNT and GHR = 0, asynchronously on arst_n low.
  - pred_hist = 0.
  - pred_taken = MSB of INIT_CNT (0 for defaults).
- Effective index:
  - Read: eidx = rd_idx ^ zero-extended GHR.
  - Update: uidx = upd_idx ^ zero-extended upd_hist.
  - HIST_W=0: eidx = rd_idx and uidx = upd_idx; pred_hist is driven 0 and upd_hist is ignored.
- Prediction:
  - Combinational, zero latency.
  - pred_taken = MSB of counter[eidx]; pred_hist = current GHR.
  - Prediction does not depend on rd_valid.
- Counter update, on the clk edge when upd_en=1:
  - upd_taken=1: counter[uidx] increments, saturating at 2^CNT_W-1.
  - upd_taken=0: counter[uidx] decrements, saturating at 0.
  - Plain saturating counter, no hysteresis jumps.
- Write-read bypass:
  - If upd_en=1 and uidx==eidx in the same cycle, pred_taken reflects the post-update counter value.
- GHR, with shift defined as ghr_next = {ghr[HIST_W-2:0], bit}:
  - upd_en & upd_mispredict: GHR <= shift of upd_hist with upd_taken. This repair has priority over a simultaneous rd_valid.
  - else rd_valid: GHR <= shift of GHR with pred_taken.
  - else: GHR holds.
  - HIST_W=1: GHR <= bit.
- upd_mispredict with upd_en=0 is ignored.
- A correctly predicted update never touches the GHR.
- Reset mid-operation discards all history and counters immediately. There is no pending state.
- Area target: 2^IDX_W*CNT_W + HIST_W flops. No SRAM macro.

Test Plan:
- Reset, defaults: after arst_n release, pred_taken=0 and pred_hist=0 for every rd_idx 0..31.
- Saturation, HIST_W=0: 3 upd_en taken at idx 7 -> counter 1->2->3->3; pred_taken=1 after the first update. Then 4 not-taken -> 2,1,0,0; pred_taken=0 after the second.
- Bypass: upd_en taken at uidx=9 with counter=1, and rd_idx=9 in the same cycle -> pred_taken=1 in that cycle.
- Speculative GHR, HIST_W=4: GHR=0, three rd_valid cycles with predictions 1,0,1 -> GHR=4'b0101. Next, rd_idx=3 reads entry 3^5=6.
- Repair priority: GHR=4'b1111, rd_valid=1 with upd_en=1, upd_mispredict=1, upd_hist=4'b0010, upd_taken=1 -> GHR=4'b0101 next cycle. The speculative shift is dropped.
- Async reset mid-run: train idx 4 to 3, assert arst_n low between edges -> pred_taken=0 and GHR=0 immediately, without waiting for a clock edge.
